// File: rtl/clint_pkg.sv
// Shared CLINT register offsets, default window base and register-select decode.
package clint_pkg;

  localparam logic [63:0] CLINT_BASE_ADDR    = 64'h0000_0000_0200_0000;
  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  typedef enum logic [1:0] {
    SEL_MSIP,
    SEL_MTIMECMP,
    SEL_MTIME,
    SEL_NONE
  } clint_sel_t;

  // Exact match only, so misaligned offsets fall through to SEL_NONE.
  function automatic clint_sel_t clint_decode(logic [15:0] off);
    case (off)
      CLINT_MSIP_OFF:     return SEL_MSIP;
      CLINT_MTIMECMP_OFF: return SEL_MTIMECMP;
      CLINT_MTIME_OFF:    return SEL_MTIME;
      default:            return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// mtime prescaler: one-cycle tick every TICK_DIV clocks (every cycle when TICK_DIV=1).
// Free-running, no backpressure; tick is combinational from the counter state.
module clint_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [15:0] cnt;

  assign tick = (cnt == 16'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// CLINT: mtime/mtimecmp/msip on a valid/ready slave; response registered one cycle after accept.
// Backpressure: req_ready = ~resp_valid | resp_ready, so one response outstanding at most.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(CLINT_BASE_ADDR),
  parameter int unsigned       TICK_DIV  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                clint_mtip,
  output logic                clint_msip
);

  logic              tick;
  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] offset;
  clint_sel_t        sel;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] mtime, mtime_inc, mtime_next;
  logic [DATA_W-1:0] mtimecmp, mtimecmp_next;
  logic              msip, msip_next;
  logic [DATA_W-1:0] rdata_sel;

  clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign req_ready  = ~resp_valid | resp_ready;
  assign accept     = req_valid & req_ready;
  assign wr_en      = accept & req_write;
  assign clint_msip = msip;

  // Addresses below the base wrap to a huge offset and miss the 64 KiB window.
  assign offset = req_addr - BASE_ADDR;
  assign sel    = (offset[ADDR_W-1:16] == '0) ? clint_decode(offset[15:0]) : SEL_NONE;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < DATA_W/8; b++) begin
      wmask[b*8 +: 8] = {8{req_wstrb[b]}};
    end
  end

  assign mtime_inc = tick ? mtime + DATA_W'(1) : mtime;

  // Written bytes override; unwritten mtime bytes still take the same-edge tick.
  always_comb begin
    mtime_next    = mtime_inc;
    mtimecmp_next = mtimecmp;
    msip_next     = msip;
    if (wr_en) begin
      case (sel)
        SEL_MSIP:     if (req_wstrb[0]) msip_next = req_wdata[0];
        SEL_MTIMECMP: mtimecmp_next = (req_wdata & wmask) | (mtimecmp & ~wmask);
        SEL_MTIME:    mtime_next = (req_wdata & wmask) | (mtime_inc & ~wmask);
        default:      ;
      endcase
    end
  end

  always_comb begin
    rdata_sel = '0;
    if (!req_write) begin
      case (sel)
        SEL_MSIP:     rdata_sel = DATA_W'(msip);
        SEL_MTIMECMP: rdata_sel = mtimecmp;
        SEL_MTIME:    rdata_sel = mtime;
        default:      rdata_sel = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      clint_mtip <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      mtime      <= mtime_next;
      mtimecmp   <= mtimecmp_next;
      msip       <= msip_next;
      clint_mtip <= (mtime_next >= mtimecmp_next);
      if (accept) begin
        resp_valid <= 1'b1;
        resp_rdata <= rdata_sel;
        resp_err   <= (sel == SEL_NONE);
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: two instances (TICK_DIV=1 and 4) share one stimulus stream,
// each checked against an arithmetic model of mtime derived from the edge count since reset.
module tb_clint_timer;

  localparam logic [63:0] BASE  = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP = BASE;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_MT   = BASE + 64'hBFF8;

  typedef struct packed {
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        resp_ready = 1'b0;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_mtip, a_msip;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mtip, b_msip;
  logic [63:0] a_rdata, b_rdata;

  always #5 clk = ~clk;

  clint_timer #(.TICK_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_rdata(a_rdata),
    .resp_err(a_resp_err), .clint_mtip(a_mtip), .clint_msip(a_msip)
  );

  clint_timer #(.TICK_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_rdata(b_rdata),
    .resp_err(b_resp_err), .clint_mtip(b_mtip), .clint_msip(b_msip)
  );

  int checks = 0;
  int failures = 0;
  int rr_pct = 100;
  bit mon_en = 1'b0;

  // Model: mtime after edge nn = aval + (ticks up to nn) - (ticks up to an), ticks = nn / div.
  longint unsigned n;
  int              outstanding;
  longint unsigned aval [2];
  longint unsigned an   [2];
  longint unsigned cmpm [2];
  logic            msipm[2];
  longint unsigned dv   [2] = '{64'd1, 64'd4};
  exp_t            q0[$];
  exp_t            q1[$];

  function automatic longint unsigned mt(int d, longint unsigned nn);
    return aval[d] + (nn / dv[d] - an[d] / dv[d]);
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw, logic [7:0] strb);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic int decode(logic [63:0] a);
    if (a == A_MSIP) return 0;
    if (a == A_CMP)  return 1;
    if (a == A_MT)   return 2;
    return 3;
  endfunction

  function automatic void model_reset();
    n = 0;
    outstanding = 0;
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      aval[d] = 0; an[d] = 0; cmpm[d] = '1; msipm[d] = 1'b0;
    end
  endfunction

  task automatic chk(string name, int d, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h at %0t", name, d, act, req, $time);
    end
  endtask

  // Model update on every accepted request / completed handshake.
  initial begin
    longint unsigned nn;
    bit acc, hs;
    int sel;
    logic [63:0] cur;
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        nn  = n + 1;
        acc = req_valid && (outstanding == 0 || resp_ready);
        hs  = (outstanding != 0) && resp_ready;
        if (acc) begin
          sel = decode(req_addr);
          for (int d = 0; d < 2; d++) begin
            case (sel)
              0:       cur = {63'd0, msipm[d]};
              1:       cur = cmpm[d];
              2:       cur = mt(d, n);
              default: cur = '0;
            endcase
            e.err   = (sel == 3);
            e.rdata = (req_write || sel == 3) ? 64'd0 : cur;
            if (req_write) begin
              case (sel)
                0: if (req_wstrb[0]) msipm[d] = req_wdata[0];
                1: cmpm[d] = merge(cmpm[d], req_wdata, req_wstrb);
                2: begin aval[d] = merge(mt(d, nn), req_wdata, req_wstrb); an[d] = nn; end
                default: ;
              endcase
            end
            if (d == 0) q0.push_back(e); else q1.push_back(e);
          end
        end
        outstanding = outstanding - int'(hs) + int'(acc);
        n = nn;
      end
    end
  end

  // Monitor: sampled 1 time unit after the falling edge, once inputs have settled.
  initial begin
    exp_t e;
    logic rv, rr_o, er, mi, ms;
    logic [63:0] rd;
    bit empty;
    forever begin
      @(negedge clk); #1;
      if (rst_n && mon_en) begin
        for (int d = 0; d < 2; d++) begin
          rv = d == 0 ? a_resp_valid : b_resp_valid;
          rr_o = d == 0 ? a_req_ready : b_req_ready;
          er = d == 0 ? a_resp_err : b_resp_err;
          mi = d == 0 ? a_mtip : b_mtip;
          ms = d == 0 ? a_msip : b_msip;
          rd = d == 0 ? a_rdata : b_rdata;
          chk("resp_valid", d, rv, outstanding != 0);
          chk("req_ready", d, rr_o, (outstanding == 0) || resp_ready);
          chk("mtip", d, mi, mt(d, n) >= cmpm[d]);
          chk("msip", d, ms, msipm[d]);
          if (rv) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
              checks++; failures++;
              $display("FAIL resp_unexpected dut%0d actual=valid required=idle at %0t", d, $time);
            end else begin
              e = (d == 0) ? q0[0] : q1[0];
              chk("rdata", d, rd, e.rdata);
              chk("resp_err", d, er, e.err);
              if (resp_ready) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
              end
            end
          end
        end
        chk("tick_div4", 1, dut_b.u_tick.tick, (n % 4) == 3);
      end
    end
  end

  task automatic set_rr();
    resp_ready = ($urandom_range(0, 99) < rr_pct);
  endtask

  task automatic idle(int k);
    repeat (k) begin
      req_valid = 1'b0;
      set_rr();
      @(negedge clk);
    end
  endtask

  // Leaves req_valid high on return; the next issue/idle call overwrites it before the edge.
  task automatic issue(bit wr, logic [63:0] a, logic [63:0] wd, logic [7:0] st);
    bit acc;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = st;
    set_rr();
    for (int k = 0; k < 64; k++) begin
      acc = (outstanding == 0) || resp_ready;
      @(negedge clk);
      if (acc) return;
      set_rr();
    end
    checks++; failures++;
    $display("FAIL req_accept_timeout actual=not_accepted required=accepted addr=%h", a);
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    resp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_resp_valid", 0, a_resp_valid, 0); chk("rst_resp_valid", 1, b_resp_valid, 0);
    chk("rst_req_ready", 0, a_req_ready, 1);   chk("rst_req_ready", 1, b_req_ready, 1);
    chk("rst_rdata", 0, a_rdata, 0);           chk("rst_rdata", 1, b_rdata, 0);
    chk("rst_err", 0, a_resp_err, 0);          chk("rst_err", 1, b_resp_err, 0);
    chk("rst_mtip", 0, a_mtip, 0);             chk("rst_mtip", 1, b_mtip, 0);
    chk("rst_msip", 0, a_msip, 0);             chk("rst_msip", 1, b_msip, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    logic [63:0] a, wd;
    logic [7:0]  st;
    bit          wr;

    do_reset();
    idle(10);
    issue(0, A_MT, 64'd0, 8'hFF);
    idle(2);

    do_reset();
    idle(40);
    issue(0, A_MT, 64'd0, 8'hFF);
    idle(2);

    do_reset();
    issue(1, A_CMP, 64'd20, 8'hFF);
    idle(25);
    issue(1, A_CMP, 64'd1000, 8'hFF);
    idle(3);

    issue(1, A_CMP, '1, 8'hFF);
    issue(1, A_MT, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    idle(12);

    issue(1, A_MSIP, '1, 8'hFF);
    issue(0, A_MSIP, 64'd0, 8'hFF);
    issue(1, A_MSIP, 64'd0, 8'hFF);
    issue(0, A_MSIP, 64'd0, 8'hFF);
    idle(2);

    issue(0, BASE + 64'h1000, 64'd0, 8'hFF);
    issue(0, BASE + 64'hBFFC, 64'd0, 8'hFF);
    issue(1, BASE + 64'h1000, '1, 8'hFF);
    issue(1, A_MT + 64'd4, '1, 8'hFF);
    idle(2);

    rr_pct = 0;
    issue(0, A_MT, 64'd0, 8'hFF);
    idle(5);
    rr_pct = 100;
    idle(2);

    issue(1, A_CMP, '1, 8'hFF);
    issue(1, A_CMP, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    issue(0, A_CMP, 64'd0, 8'hFF);
    idle(2);

    rr_pct = 0;
    issue(0, A_MT, 64'd0, 8'hFF);
    idle(1);
    do_reset();
    rr_pct = 70;

    repeat (400) begin
      wr = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      wd = {$urandom, $urandom};
      case ($urandom_range(0, 6))
        0: a = A_MSIP;
        1: begin a = A_CMP; wd = mt(0, n) + 64'($urandom_range(0, 40)); end
        2: begin
          a = A_MT;
          if ($urandom_range(0, 1) == 0) wd = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
          else wd = 64'($urandom_range(0, 200));
        end
        3: a = BASE + 64'h1000;
        4: a = A_MT + 64'd4;
        5: a = BASE + 64'h1_0000;
        default: a = BASE - 64'd8;
      endcase
      issue(wr, a, wd, st);
      idle($urandom_range(0, 2));
    end

    rr_pct = 100;
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor (CLINT) for the single-hart core. Holds the mtime counter, mtimecmp and msip registers, and exposes them as memory-mapped registers on a valid/ready slave port driven by the load/store unit.
- Generates the level-sensitive timer pending line clint_mtip, which feeds the CSR file's mip.MTIP/mcause path, and the software interrupt line clint_msip.

Parameters:
- DATA_W, 64, register and data width.
- ADDR_W, 64, request address width.
- BASE_ADDR, 64'h0200_0000, base of the CLINT window.
- TICK_DIV, 1, clk cycles per mtime increment; legal range 1..65535.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  slave can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte enables.
- resp_valid  out  1  response valid.
- resp_ready  in  1  master accepts the response.
- resp_rdata  out  DATA_W  read data; 0 on writes and on errors.
- resp_err  out  1  unmapped address.
- clint_mtip  out  1  timer interrupt pending.
- clint_msip  out  1  software interrupt pending.

Behaviour:
- Register map (8-byte aligned; offsets from BASE_ADDR):
  - 0x0000: msip; only bit 0 is writable, upper bits read 0.
  - 0x4000: mtimecmp.
  - 0xBFF8: mtime.
  - Any other address, or a misaligned addr[2:0]≠0: resp_err=1, no side effect.
- Reset (asynchronous on rst_n low):
  - mtime=0, mtimecmp=all-ones, msip=0, prescaler=0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - clint_mtip=0, clint_msip=0.
  - Reset mid-transaction drops the in-flight response silently.
- Handshake:
  - Request accepted when req_valid & req_ready.
  - resp_valid rises the following cycle and holds, with resp_rdata/resp_err stable, until resp_valid & resp_ready.
  - req_ready = ~resp_valid | resp_ready, so back-to-back requests give one response per cycle. At most one response is outstanding.
- Writes take effect on the accept edge. Each byte lane is updated only where req_wstrb is set.
- Read data is the register value sampled at the accept edge, before any same-edge tick.
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1. The tick pulse is asserted when prescaler==TICK_DIV-1, and the prescaler then returns to 0.
  - TICK_DIV=1 gives a tick every cycle.
  - mtime += 1 on tick; wraps from 2^64-1 to 0 with no flag.
- Simultaneous events:
  - An mtime write and a tick on the same edge: the written bytes win and unwritten bytes take the incremented value. The prescaler is not reset.
  - A mtimecmp write on the same edge as a tick: the new mtimecmp is used from the next compare onward.
- clint_mtip is registered: clint_mtip <= (mtime_next >= mtimecmp_next), unsigned 64-bit compare on next-state values. It is therefore valid in the same cycle the new values become visible.
  - Writing mtimecmp greater than mtime deasserts clint_mtip in the cycle after the accept.
- clint_msip is msip[0], directly from the register.
- No interrupt masking here; masking lives in the CSR file.

Decomposition:
- Shared package clint_pkg:
  - Offset constants CLINT_MSIP_OFF, CLINT_MTIMECMP_OFF, CLINT_MTIME_OFF.
  - CLINT_BASE_ADDR default.
  - The register-select enum {SEL_MSIP, SEL_MTIMECMP, SEL_MTIME, SEL_NONE}.
- One sub-module, clint_tick_gen:
  - Contains the prescaler counter only; parameter TICK_DIV.
  - Ports clk, rst_n, tick.
- The top level keeps the decode, registers, compare and handshake.

Test Plan:
- Reset release, TICK_DIV=1, no traffic for 10 cycles -> mtime reads 10 (±1 for the read edge), clint_mtip=0, clint_msip=0, resp_err=0.
- TICK_DIV=4, run 40 cycles, read mtime -> 10. Tick pulses are exactly every 4th cycle.
- Write mtimecmp=20 with mtime near 0, TICK_DIV=1 -> clint_mtip rises in the cycle mtime reaches 20. Then write mtimecmp=1000 -> clint_mtip falls one cycle after the accept.
- Write mtime=64'hFFFF_FFFF_FFFF_FFFE with mtimecmp=all-ones -> clint_mtip=1 at ...FFFF. mtime then wraps to 0 and clint_mtip returns to 0.
- Write msip wdata=64'hFFFF_FFFF_FFFF_FFFF -> clint_msip=1 and a read back returns 1. Write 0 -> clint_msip=0.
- Protocol edge cases:
  - Read at BASE+0x1000 -> resp_err=1, rdata=0.
  - Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable and req_ready=0 throughout.
  - wstrb=8'h0F write of 64'hAAAA_BBBB_CCCC_DDDD to mtimecmp=all-ones -> FFFF_FFFF_CCCC_DDDD.
  - rst_n pulsed low mid-response -> all outputs return to their reset values immediately.
